// File: rtl/ascii_to_morse_tx.sv
// ASCII-to-Morse transmitter: one character per start/ready handshake, ITU unit timing.
// Define LOWERCASE_EN to fold 'a'-'z' onto 'A'-'Z' before the code lookup.
module ascii_to_morse_tx #(
   parameter int unsigned UNIT_CYCLES = 5_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ascii_in,
   input  logic       start,
   output logic       ready,
   output logic       morse_out,
   output logic       done,
   output logic       invalid
);

   localparam int unsigned UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [UW-1:0] U_LAST = UW'(UNIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MARK,
      S_GAP,
      S_TAIL,
      S_WORD
   } state_e;

   state_e        state_q;
   logic [9:0]    code_q;
   logic [2:0]    idx_q;
   logic [UW-1:0] unit_q;
   logic [2:0]    mult_q;
   logic          ready_q;
   logic          morse_q;
   logic          done_q;
   logic          invalid_q;

   logic [7:0]    char_d;
   logic [9:0]    code_d;
   logic          valid_d;
   logic          space_d;
   logic [2:0]    last_d;
   logic          unit_end;
   logic          phase_end;
   logic          more_d;

`ifdef LOWERCASE_EN
   always_comb begin
      char_d = ascii_in;
      if (ascii_in >= 8'h61 && ascii_in <= 8'h7A) begin
         char_d = ascii_in - 8'h20;
      end
   end
`else
   assign char_d = ascii_in;
`endif

   // Pairs MSB first: 10 = dot, 11 = dash, 00 = end of code.
   always_comb begin
      code_d  = 10'b00_00_00_00_00;
      valid_d = 1'b1;
      case (char_d)
         8'h41: code_d = 10'b10_11_00_00_00;
         8'h42: code_d = 10'b11_10_10_10_00;
         8'h43: code_d = 10'b11_10_11_10_00;
         8'h44: code_d = 10'b11_10_10_00_00;
         8'h45: code_d = 10'b10_00_00_00_00;
         8'h46: code_d = 10'b10_10_11_10_00;
         8'h47: code_d = 10'b11_11_10_00_00;
         8'h48: code_d = 10'b10_10_10_10_00;
         8'h49: code_d = 10'b10_10_00_00_00;
         8'h4A: code_d = 10'b10_11_11_11_00;
         8'h4B: code_d = 10'b11_10_11_00_00;
         8'h4C: code_d = 10'b10_11_10_10_00;
         8'h4D: code_d = 10'b11_11_00_00_00;
         8'h4E: code_d = 10'b11_10_00_00_00;
         8'h4F: code_d = 10'b11_11_11_00_00;
         8'h50: code_d = 10'b10_11_11_10_00;
         8'h51: code_d = 10'b11_11_10_11_00;
         8'h52: code_d = 10'b10_11_10_00_00;
         8'h53: code_d = 10'b10_10_10_00_00;
         8'h54: code_d = 10'b11_00_00_00_00;
         8'h55: code_d = 10'b10_10_11_00_00;
         8'h56: code_d = 10'b10_10_10_11_00;
         8'h57: code_d = 10'b10_11_11_00_00;
         8'h58: code_d = 10'b11_10_10_11_00;
         8'h59: code_d = 10'b11_10_11_11_00;
         8'h5A: code_d = 10'b11_11_10_10_00;
         8'h30: code_d = 10'b11_11_11_11_11;
         8'h31: code_d = 10'b10_11_11_11_11;
         8'h32: code_d = 10'b10_10_11_11_11;
         8'h33: code_d = 10'b10_10_10_11_11;
         8'h34: code_d = 10'b10_10_10_10_11;
         8'h35: code_d = 10'b10_10_10_10_10;
         8'h36: code_d = 10'b11_10_10_10_10;
         8'h37: code_d = 10'b11_11_10_10_10;
         8'h38: code_d = 10'b11_11_11_10_10;
         8'h39: code_d = 10'b11_11_11_11_10;
         8'h20: code_d = 10'b00_00_00_00_00;
         default: valid_d = 1'b0;
      endcase
   end

   assign space_d = (char_d == 8'h20);

   // Length of the current phase in units, minus one.
   always_comb begin
      last_d = 3'd0;
      case (state_q)
         S_MARK:  last_d = (code_q[9:8] == 2'b11) ? 3'd2 : 3'd0;
         S_GAP:   last_d = 3'd0;
         S_TAIL:  last_d = 3'd2;
         S_WORD:  last_d = 3'd6;
         default: last_d = 3'd0;
      endcase
   end

   assign unit_end  = (unit_q == U_LAST);
   assign phase_end = unit_end && (mult_q == last_d);
   assign more_d    = (idx_q < 3'd4) && (code_q[7:6] != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         code_q    <= '0;
         idx_q     <= '0;
         unit_q    <= '0;
         mult_q    <= '0;
         ready_q   <= 1'b1;
         morse_q   <= 1'b0;
         done_q    <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         invalid_q <= 1'b0;
         if (state_q != S_IDLE) begin
            if (phase_end) begin
               unit_q <= '0;
               mult_q <= '0;
            end else begin
               unit_q <= unit_end ? '0 : unit_q + UW'(1);
               mult_q <= unit_end ? mult_q + 3'd1 : mult_q;
            end
         end
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  code_q <= code_d;
                  idx_q  <= '0;
                  unit_q <= '0;
                  mult_q <= '0;
                  if (!valid_d) begin
                     invalid_q <= 1'b1;
                  end else if (space_d) begin
                     state_q <= S_WORD;
                     ready_q <= 1'b0;
                  end else begin
                     state_q <= S_MARK;
                     ready_q <= 1'b0;
                     morse_q <= 1'b1;
                  end
               end
            end
            S_MARK: begin
               if (phase_end) begin
                  morse_q <= 1'b0;
                  if (more_d) begin
                     state_q <= S_GAP;
                     idx_q   <= idx_q + 3'd1;
                     code_q  <= {code_q[7:0], 2'b00};
                  end else begin
                     state_q <= S_TAIL;
                  end
               end
            end
            S_GAP: begin
               if (phase_end) begin
                  state_q <= S_MARK;
                  morse_q <= 1'b1;
               end
            end
            S_TAIL, S_WORD: begin
               if (phase_end) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               morse_q <= 1'b0;
            end
         endcase
      end
   end

   assign ready     = ready_q;
   assign morse_out = morse_q;
   assign done      = done_q;
   assign invalid   = invalid_q;

endmodule

// File: tb/tb_ascii_to_morse_tx.sv
// Bench for ascii_to_morse_tx: dot/dash strings expanded into a per-cycle waveform.
// Honours LOWERCASE_EN the same way as the design.
module tb_ascii_to_morse_tx;

   localparam int U = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ascii_in = 8'h00;
   logic       start = 1'b0;
   logic       ready;
   logic       morse_out;
   logic       done;
   logic       invalid;

   int checks = 0;
   int errors = 0;

   bit exp_q[$];
   bit exp_bad;

   string letters [26] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
      "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
      "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
      "-.--", "--.."
   };
   string digits [10] = '{
      "-----", ".----", "..---", "...--", "....-",
      ".....", "-....", "--...", "---..", "----."
   };

   always #5 clk = ~clk;

   ascii_to_morse_tx #(.UNIT_CYCLES(U)) dut (
      .clk(clk),
      .rst(rst),
      .ascii_in(ascii_in),
      .start(start),
      .ready(ready),
      .morse_out(morse_out),
      .done(done),
      .invalid(invalid)
   );

   // Expected morse_out per cycle after acceptance, up to the done cycle.
   task automatic model(input logic [7:0] c);
      logic [7:0] u;
      string s;
      exp_q.delete();
      exp_bad = 1'b0;
      u = c;
`ifdef LOWERCASE_EN
      if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
`endif
      if (u >= 8'h41 && u <= 8'h5A) begin
         s = letters[u - 8'h41];
      end else if (u >= 8'h30 && u <= 8'h39) begin
         s = digits[u - 8'h30];
      end else if (u == 8'h20) begin
         for (int i = 0; i < 7 * U; i++) exp_q.push_back(1'b0);
         return;
      end else begin
         exp_bad = 1'b1;
         return;
      end
      for (int j = 0; j < s.len(); j++) begin
         int n;
         n = (s[j] == "-") ? 3 * U : U;
         for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
         if (j < s.len() - 1)
            for (int i = 0; i < U; i++) exp_q.push_back(1'b0);
      end
      for (int i = 0; i < 3 * U; i++) exp_q.push_back(1'b0);
   endtask

   // Caller has driven start/ascii_in for ch before the accepting edge.
   task automatic play(input logic [7:0] ch, input bit noise,
                       input bit chain, input logic [7:0] nxt);
      logic [3:0] got;
      logic [3:0] want;
      model(ch);
      @(posedge clk);
      if (exp_bad) begin
         @(negedge clk);
         got  = {morse_out, ready, done, invalid};
         want = 4'b0101;
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL inv_pulse ch=%h got=%b want=%b", ch, got, want);
         end
         start = 1'b0;
         @(negedge clk);
         got  = {morse_out, ready, done, invalid};
         want = 4'b0100;
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL inv_after ch=%h got=%b want=%b", ch, got, want);
         end
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            got  = {morse_out, ready, done, invalid};
            want = {exp_q[i], 3'b000};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL wave ch=%h cyc=%0d got=%b want=%b",
                        ch, i, got, want);
            end
            if (noise) begin
               start    = 1'($urandom);
               ascii_in = 8'($urandom);
            end else begin
               start = 1'b0;
            end
         end
         @(negedge clk);
         got  = {morse_out, ready, done, invalid};
         want = 4'b0110;
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL done ch=%h cyc=%0d got=%b want=%b",
                     ch, exp_q.size(), got, want);
         end
      end
      start = 1'b0;
      if (chain) begin
         ascii_in = nxt;
         start    = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] ch, input bit noise);
      @(negedge clk);
      ascii_in = ch;
      start    = 1'b1;
      play(ch, noise, 1'b0, 8'h00);
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      ascii_in = 8'h45;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({morse_out, ready, done, invalid} !== 4'b0100) begin
         errors++;
         $display("FAIL reset got=%b want=0100",
                  {morse_out, ready, done, invalid});
      end
      start = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic test_directed();
      send(8'h45, 1'b0);
      send(8'h41, 1'b0);
      send(8'h30, 1'b0);
      send(8'h35, 1'b0);
      send(8'h58, 1'b0);
      send(8'h20, 1'b0);
      send(8'h23, 1'b0);
   endtask

   task automatic test_lowercase();
      send(8'h61, 1'b0);
      send(8'h7A, 1'b0);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      ascii_in = 8'h54;
      start    = 1'b1;
      play(8'h54, 1'b0, 1'b1, 8'h54);
      play(8'h54, 1'b0, 1'b1, 8'h20);
      play(8'h20, 1'b0, 1'b1, 8'h23);
      play(8'h23, 1'b0, 1'b1, 8'h4E);
      play(8'h4E, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      ascii_in = 8'h4F;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({morse_out, ready} !== 2'b10) begin
         errors++;
         $display("FAIL mid_dash got=%b want=10", {morse_out, ready});
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({morse_out, ready, done, invalid} !== 4'b0100) begin
         errors++;
         $display("FAIL mid_reset got=%b want=0100",
                  {morse_out, ready, done, invalid});
      end
      rst = 1'b0;
      repeat (3 * U) @(negedge clk);
      checks++;
      if ({morse_out, ready, done, invalid} !== 4'b0100) begin
         errors++;
         $display("FAIL post_reset got=%b want=0100",
                  {morse_out, ready, done, invalid});
      end
      send(8'h45, 1'b0);
   endtask

   task automatic test_random();
      logic [7:0] c;
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 4))
            0: c = 8'(8'h41 + $urandom_range(0, 25));
            1: c = 8'(8'h30 + $urandom_range(0, 9));
            2: c = 8'(8'h61 + $urandom_range(0, 25));
            3: c = 8'h20;
            default: c = 8'($urandom);
         endcase
         send(c, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_lowercase();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
